// File: rtl/imem_line_responder_if.sv
// Line-fill request/response bundle between the i-cache miss port and the line responder,
// plus the backing-store write port used to preload or patch the store.
interface imem_line_responder_if #(
    parameter int unsigned DATA_WIDHT     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 12
);
    logic                      i_req_valid;
    logic [ADDRESS_WIDTH-1:0]  i_req_address;
    logic                      i_wr_en;
    logic [MEM_ADDR_WIDTH-1:0] i_wr_address;
    logic [DATA_WIDHT-1:0]     i_wr_data;
    logic                      o_valid;
    logic                      o_last;
    logic [DATA_WIDHT-1:0]     o_data;
    logic                      o_busy;

    modport master (
        output i_req_valid, i_req_address, i_wr_en, i_wr_address, i_wr_data,
        input  o_valid, o_last, o_data, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_address, i_wr_en, i_wr_address, i_wr_data,
        output o_valid, o_last, o_data, o_busy
    );
endinterface

// File: rtl/imem_line_responder.sv
// Memory-side line-fill responder: accepts a held line request and streams the whole
// line from a synchronous backing store as a BURST_LEN-beat burst after a fixed latency.
module imem_line_responder #(
    parameter int unsigned DATA_WIDHT     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned OFFSET_WIDTH   = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_line_responder_if.slave  bus
);
    localparam int unsigned LINE_WIDTH = MEM_ADDR_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LAT_W      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                  state, state_next;
    logic [LAT_W-1:0]        wait_cnt;
    logic [OFFSET_WIDTH-1:0] beat;
    logic [LINE_WIDTH-1:0]   line;
    logic                    valid_q, last_q, busy_q;
    logic [DATA_WIDHT-1:0]   data_q;
    logic [DATA_WIDHT-1:0]   mem [0:(2**MEM_ADDR_WIDTH)-1];
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{bus.i_req_address[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH],
                                bus.i_req_address[OFFSET_WIDTH-1:0]};

    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_data  = data_q;
    assign bus.o_busy  = busy_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_req_valid) state_next = (LATENCY == 0) ? BURST : WAIT;
            WAIT:    if (wait_cnt <= LAT_W'(1)) state_next = BURST;
            BURST:   if (beat == '1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs trail the state by one edge, so busy is held through the edge leaving DONE
    // to make the dead cycle visible as busy with no beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            beat     <= '0;
            line     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state   <= state_next;
            busy_q  <= (state_next != IDLE) || (state == DONE);
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        line     <= bus.i_req_address[MEM_ADDR_WIDTH-1:OFFSET_WIDTH];
                        beat     <= '0;
                        wait_cnt <= LAT_W'(LATENCY);
                    end
                end
                WAIT: wait_cnt <= wait_cnt - LAT_W'(1);
                BURST: begin
                    valid_q <= 1'b1;
                    last_q  <= (beat == '1);
                    data_q  <= mem[{line, beat}];
                    beat    <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write port is independent of the FSM; same-word read in the same cycle sees old data.
    always_ff @(posedge clk) begin
        if (bus.i_wr_en) mem[bus.i_wr_address] <= bus.i_wr_data;
    end
endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: cycle-table for fill/patch/back-to-back/drop,
// hand sequences for mid-burst reset and a zero-latency wrapped-address instance.
module tb_imem_line_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_line_responder_if #(.DATA_WIDHT(32), .ADDRESS_WIDTH(32), .MEM_ADDR_WIDTH(12)) bus ();
    imem_line_responder_if #(.DATA_WIDHT(32), .ADDRESS_WIDTH(32), .MEM_ADDR_WIDTH(12)) bus0 ();

    imem_line_responder #(.DATA_WIDHT(32), .ADDRESS_WIDTH(32), .OFFSET_WIDTH(4),
                          .MEM_ADDR_WIDTH(12), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    imem_line_responder #(.DATA_WIDHT(32), .ADDRESS_WIDTH(32), .OFFSET_WIDTH(4),
                          .MEM_ADDR_WIDTH(12), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        logic        req_v;
        logic [31:0] req_a;
        logic        wr_en;
        logic [11:0] wr_a;
        logic [31:0] wr_d;
        logic        ev;
        logic        el;
        logic        eb;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(logic rv, logic [31:0] ra, logic we, logic [11:0] wa,
                                logic [31:0] wd, logic ev, logic el, logic eb, logic [31:0] ed);
        vec_t v;
        v.req_v = rv; v.req_a = ra; v.wr_en = we; v.wr_a = wa; v.wr_d = wd;
        v.ev = ev; v.el = el; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {valid, last, busy, data} of the selected instance
    function automatic logic [34:0] outs(bit sel);
        if (sel) return {bus0.o_valid, bus0.o_last, bus0.o_busy, bus0.o_data};
        return {bus.o_valid, bus.o_last, bus.o_busy, bus.o_data};
    endfunction

    task automatic set_req(bit sel, logic v, logic [31:0] a);
        if (sel) begin bus0.i_req_valid = v; bus0.i_req_address = a; end
        else begin bus.i_req_valid = v; bus.i_req_address = a; end
    endtask

    task automatic fill(input bit sel, input logic [31:0] addr, input int lat,
                        input logic [31:0] exp [16], input string tag);
        logic [34:0] o;
        int n;
        set_req(sel, 1'b1, addr);
        tick();
        set_req(sel, 1'b0, 32'h0);
        n = 0;
        o = outs(sel);
        while (!o[34] && n < 50) begin
            tick();
            n++;
            o = outs(sel);
        end
        chk({tag, " first-beat latency"}, 32'(n), 32'(lat + 1));
        for (int b = 0; b < 16; b++) begin
            o = outs(sel);
            chk($sformatf("%s beat%0d valid", tag, b), {31'b0, o[34]}, 32'd1);
            chk($sformatf("%s beat%0d last", tag, b), {31'b0, o[33]}, {31'b0, (b == 15)});
            chk($sformatf("%s beat%0d data", tag, b), o[31:0], exp[b]);
            tick();
        end
        o = outs(sel);
        chk({tag, " done valid"}, {31'b0, o[34]}, 32'd0);
        chk({tag, " done busy"}, {31'b0, o[32]}, 32'd1);
        tick();
        o = outs(sel);
        chk({tag, " idle busy"}, {31'b0, o[32]}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_a [16];
        logic [31:0] exp_c [16];
        logic [34:0] o;
        int n;

        // Cycle table: fill of line 0x100 with mid-burst patches, held request re-accepted
        // after one dead cycle (address changed to 0x200 early), then request dropped mid-burst.
        add(1, 32'h105, 0, 0, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 4; i++) add(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h0);
        for (int b = 0; b < 16; b++)
            add(1, 32'h200, (b == 3) || (b == 4), (b == 3) ? 12'h10A : 12'h101,
                (b == 3) ? 32'hDEAD_BEEF : 32'h1234_5678,
                1, (b == 15), 1, (b == 10) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(b));
        add(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hA000_000F);
        add(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hA000_000F);
        for (int i = 0; i < 4; i++) add(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'hA000_000F);
        for (int b = 0; b < 16; b++)
            add((b < 3), 32'h200, 0, 0, 0, 1, (b == 15), 1, 32'hB000_0000 + 32'(b));
        add(0, 32'h0, 0, 0, 0, 0, 0, 1, 32'hB000_000F);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'hB000_000F);
        add(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'hB000_000F);

        bus.i_req_valid = 0; bus.i_req_address = '0; bus.i_wr_en = 0;
        bus.i_wr_address = '0; bus.i_wr_data = '0;
        bus0.i_req_valid = 0; bus0.i_req_address = '0; bus0.i_wr_en = 0;
        bus0.i_wr_address = '0; bus0.i_wr_data = '0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        o = outs(0);
        chk("reset valid", {31'b0, o[34]}, 32'd0);
        chk("reset last", {31'b0, o[33]}, 32'd0);
        chk("reset busy", {31'b0, o[32]}, 32'd0);
        chk("reset data", o[31:0], 32'd0);

        for (int i = 0; i < 16; i++) begin
            bus.i_wr_en = 1; bus.i_wr_address = 12'h100 + 12'(i); bus.i_wr_data = 32'hA000_0000 + 32'(i);
            bus0.i_wr_en = 1; bus0.i_wr_address = 12'hFF0 + 12'(i); bus0.i_wr_data = 32'hC000_0000 + 32'(i);
            tick();
            bus.i_wr_address = 12'h200 + 12'(i); bus.i_wr_data = 32'hB000_0000 + 32'(i);
            bus0.i_wr_en = 0;
            tick();
        end
        bus.i_wr_en = 0;
        tick();

        for (int k = 0; k < tbl.size(); k++) begin
            bus.i_req_valid = tbl[k].req_v; bus.i_req_address = tbl[k].req_a;
            bus.i_wr_en = tbl[k].wr_en; bus.i_wr_address = tbl[k].wr_a; bus.i_wr_data = tbl[k].wr_d;
            tick();
            o = outs(0);
            chk($sformatf("row%0d valid", k), {31'b0, o[34]}, {31'b0, tbl[k].ev});
            chk($sformatf("row%0d last", k), {31'b0, o[33]}, {31'b0, tbl[k].el});
            chk($sformatf("row%0d busy", k), {31'b0, o[32]}, {31'b0, tbl[k].eb});
            chk($sformatf("row%0d data", k), o[31:0], tbl[k].ed);
        end
        bus.i_wr_en = 0;

        for (int b = 0; b < 16; b++) exp_a[b] = 32'hA000_0000 + 32'(b);
        exp_a[1]  = 32'h1234_5678;
        exp_a[10] = 32'hDEAD_BEEF;

        // Mid-burst reset at beat 7, then a clean refill starting from beat 0.
        set_req(0, 1'b1, 32'h10C);
        tick();
        set_req(0, 1'b0, 32'h0);
        n = 0;
        while (!bus.o_valid && n < 50) begin tick(); n++; end
        chk("rst-seq latency", 32'(n), 32'd5);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("rst-seq beat%0d data", b), bus.o_data, exp_a[b]);
            if (b < 7) tick();
        end
        rst = 1;
        tick();
        rst = 0;
        o = outs(0);
        chk("post-rst valid", {31'b0, o[34]}, 32'd0);
        chk("post-rst last", {31'b0, o[33]}, 32'd0);
        chk("post-rst busy", {31'b0, o[32]}, 32'd0);
        chk("post-rst data", o[31:0], 32'd0);
        fill(0, 32'h100, 4, exp_a, "refill");

        // Zero-latency instance with upper address bits set: wraps into line 0xFF0.
        for (int b = 0; b < 16; b++) exp_c[b] = 32'hC000_0000 + 32'(b);
        fill(1, 32'hFFFF_FFF3, 0, exp_c, "lat0-wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
